// File: rtl/spi_slave.sv
// SPI mode-0 slave that bridges framed [R/W flag | address | data] transfers onto a register strobe bus.
// Latency: reg_rd about 1 clk after the last address bit is seen; reg_wr about 1 clk after the last data bit.
// Backpressure: none. The SPI master sets the pace, and clk must run at least 8x spi_clk.
// Ports:
//   clk, rst                       : system clock and asynchronous active-high reset.
//   spi_cs, spi_clk, spi_mosi      : asynchronous SPI inputs. Each is synchronized internally.
//   spi_miso, spi_miso_oe          : serial read data and its output enable.
//   reg_addr, reg_wr, reg_wdata    : register address and write strobe with its data.
//   reg_rd, reg_rdata              : read strobe; reg_rdata is sampled 1 clk after reg_rd.
module spi_slave #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [AWIDTH-2:0] reg_addr,
  output logic              reg_wr,
  output logic [DWIDTH-1:0] reg_wdata,
  output logic              reg_rd,
  input  logic [DWIDTH-1:0] reg_rdata
);

  localparam int MAXW = (AWIDTH > DWIDTH) ? AWIDTH : DWIDTH;
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Synchronizers. The cs stages reset to 1 so that spi_miso_oe is low during reset.
  logic              cs_s1, cs_s2, cs_q;
  logic              sclk_s1, sclk_s2, sclk_q;
  logic              mosi_s1, mosi_s2;
  logic [1:0]        sync_vld;
  logic              armed;

  logic              cs_fall, sclk_rise, sclk_fall;

  logic [AWIDTH-1:0] rx_addr;
  logic [DWIDTH-1:0] rx_data;
  logic [DWIDTH-1:0] tx_sr;
  logic              is_read;
  logic              rd_pend;
  logic              miso_q;

  logic [AWIDTH-1:0] addr_next;
  logic [DWIDTH-1:0] data_next;

  // Control decoded by the FSM.
  logic              frame_start, addr_bit, addr_last, data_bit, data_last;
  logic              miso_shift, miso_clr;

  assign cs_fall     = armed & cs_q & ~cs_s2;
  assign sclk_rise   = sclk_s2 & ~sclk_q;
  assign sclk_fall   = ~sclk_s2 & sclk_q;
  assign addr_next   = {rx_addr[AWIDTH-2:0], mosi_s2};
  assign data_next   = {rx_data[DWIDTH-2:0], mosi_s2};
  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~cs_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
      cs_q     <= 1'b1;
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      cs_s1    <= spi_cs;
      cs_s2    <= cs_s1;
      cs_q     <= cs_s2;
      sclk_s1  <= spi_clk;
      sclk_s2  <= sclk_s1;
      sclk_q   <= sclk_s2;
      mosi_s1  <= spi_mosi;
      mosi_s2  <= mosi_s1;
      sync_vld <= {sync_vld[0], 1'b1};
      // Frames are accepted only after cs_s2 holds a genuinely sampled high.
      // This keeps a frame that was in progress at reset release from
      // being picked up halfway through.
      if (sync_vld[1] && cs_s2) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_start = 1'b0;
    addr_bit    = 1'b0;
    addr_last   = 1'b0;
    data_bit    = 1'b0;
    data_last   = 1'b0;
    miso_shift  = 1'b0;
    miso_clr    = 1'b0;
    if (cs_s2) begin
      // Deselect aborts or ends a frame in any state.
      state_d  = IDLE;
      cnt_d    = '0;
      miso_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d     = ADDR;
            cnt_d       = '0;
            frame_start = 1'b1;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            addr_bit = 1'b1;
            if (cnt_q == CW'(AWIDTH - 1)) begin
              state_d   = DATA;
              cnt_d     = '0;
              addr_last = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (sclk_fall) miso_shift = 1'b1;
          if (sclk_rise) begin
            data_bit = 1'b1;
            if (cnt_q == CW'(DWIDTH - 1)) begin
              state_d   = DONE;
              cnt_d     = '0;
              data_last = 1'b1;
              miso_clr  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          // Extra spi_clk pulses are ignored until cs goes high.
          miso_clr = 1'b1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_addr   <= '0;
      rx_data   <= '0;
      tx_sr     <= '0;
      is_read   <= 1'b0;
      rd_pend   <= 1'b0;
      miso_q    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
    end else begin
      reg_wr  <= 1'b0;
      reg_rd  <= 1'b0;
      rd_pend <= reg_rd;

      if (frame_start) begin
        rx_addr <= '0;
        rx_data <= '0;
        tx_sr   <= '0;
        is_read <= 1'b0;
      end

      if (addr_bit) rx_addr <= addr_next;
      if (addr_last) begin
        reg_addr <= addr_next[AWIDTH-2:0];
        is_read  <= addr_next[AWIDTH-1];
        reg_rd   <= addr_next[AWIDTH-1];
      end

      // Read data comes back one clk after reg_rd. It reaches the first
      // falling edge of the data phase because clk is at least 8x spi_clk.
      if (rd_pend && state_q == DATA) tx_sr <= reg_rdata;

      if (data_bit) rx_data <= data_next;
      if (data_last && !is_read) begin
        reg_wdata <= data_next;
        reg_wr    <= 1'b1;
      end

      if (miso_shift) begin
        miso_q <= tx_sr[DWIDTH-1];
        tx_sr  <= {tx_sr[DWIDTH-2:0], 1'b0};
      end else if (miso_clr) begin
        miso_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter AWIDTH, default 8, frame address-field width in bits; the field MSB is the read/write flag.
REQ-002 Parameter DWIDTH, default 16, frame data-field width in bits.
REQ-003 clk  input  1  system clock; the only clock; all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 spi_cs  input  1  chip select, active low, asynchronous to clk.
REQ-006 spi_clk  input  1  SPI clock, mode 0 (idle low), asynchronous to clk.
REQ-007 spi_mosi  input  1  serial data from master, MSB first.
REQ-008 spi_miso  output  1  serial data to master.
REQ-009 spi_miso_oe  output  1  MISO output enable, high while a frame is selected.
REQ-010 reg_addr  output  AWIDTH-1  register address: address field without the R/W flag.
REQ-011 reg_wr  output  1  one-clk write strobe.
REQ-012 reg_wdata  output  DWIDTH  write data, valid while reg_wr=1.
REQ-013 reg_rd  output  1  one-clk read strobe.
REQ-014 reg_rdata  input  DWIDTH  read data, sampled exactly 1 clk after reg_rd.

Function
REQ-015 spi_cs, spi_clk and spi_mosi shall each pass through a 2-FF synchronizer before use; spi_clk edges shall be detected from the synchronized copies.
REQ-016 clk frequency shall be at least 8x the spi_clk frequency; the design need not work below that ratio.
REQ-017 Frame: AWIDTH+DWIDTH bits, MSB first, address field then data field.
- Flag (address MSB) = 1: read.
- Flag = 0: write.
REQ-018 MOSI shall be sampled on each detected spi_clk rising edge; MISO shall change only on detected spi_clk falling edges, or on cs assertion.
REQ-019 FSM states and transitions:
- IDLE -> ADDR on synchronized cs falling.
- ADDR -> DATA after AWIDTH rising edges.
- DATA -> DONE after DWIDTH further rising edges.
- DONE -> IDLE on cs high.
- Any state -> IDLE on cs high.
REQ-020 At the clk after the AWIDTH-th rising edge, reg_addr shall latch the address field.
- If flag=1, reg_rd shall pulse for exactly 1 clk at that same clk.
REQ-021 One clk after reg_rd, reg_rdata shall load the TX shift register.
- The first falling edge after that load shall drive reg_rdata[DWIDTH-1].
- Each subsequent falling edge shall drive the next lower bit.
REQ-022 spi_miso shall be 0 during the address phase, in DONE, and while cs is high.
REQ-023 For a write frame, reg_wr shall pulse for exactly 1 clk, with reg_addr and reg_wdata stable that clk.
- The pulse shall occur at the clk after the final (AWIDTH+DWIDTH-th) rising edge.
REQ-024 A read frame shall never assert reg_wr; the data field received in a read frame shall be ignored.
REQ-025 If cs deasserts before the full frame, the frame is discarded.
- No reg_wr shall be issued.
- A reg_rd already issued is not retracted.
- The bit counter shall clear.
REQ-026 spi_clk edges in DONE, or while cs is high, shall be ignored.
REQ-027 A new frame may start on the cs falling edge immediately after a cs high of at least 4 clk; no state shall carry over between frames.
REQ-028 spi_miso_oe shall equal the inverted synchronized cs.
REQ-029 reg_addr and reg_wdata shall hold their last values between frames.

Reset
REQ-030 While rst=1, outputs shall be:
- FSM: IDLE; bit counter: 0; shift registers: 0.
- spi_miso=0, spi_miso_oe=0.
- reg_wr=0, reg_rd=0.
- reg_addr=0, reg_wdata=0.
REQ-031 Reset asserted mid-frame shall abort the frame with no strobe.
- After release, the block shall wait for cs high, then a fresh cs falling, before accepting bits.

Verification
REQ-032 Write: mode-0 frame, spi_clk half-period 100 ns, clk 100 MHz, address 0x10, data 0x00AA -> exactly one reg_wr, reg_addr=0x10, reg_wdata=0x00AA, reg_rd never asserted.
REQ-033 Read: address 0x90, reg_rdata=0x1234 returned 1 clk after reg_rd -> one reg_rd with reg_addr=0x10; master captures 0x001234 on its rising-edge samples; no reg_wr.
REQ-034 Back-to-back: writes 0x00/0x00AA, 0x01/0x00BB, 0x02/0x00CC, 0x03/0x00DD, then reads 0x80..0x83 from a bench register model -> reads return 0x00AA, 0x00BB, 0x00CC, 0x00DD.
REQ-035 Abort: cs raised after 10 bits of a write frame to 0x05 -> no reg_wr; the next full write 0x06/0x1111 produces exactly one correct strobe.
REQ-036 Overrun: 4 extra spi_clk pulses after a full write frame before cs high -> still exactly one reg_wr, spi_miso=0 during the extra pulses.
REQ-037 Reset mid-frame: rst pulsed during the data phase -> all outputs at reset values, no strobe; the next frame completes correctly.
